// File: rtl/alu_pkg.sv
// Shared widths, flag bit positions and FSM state type for the ALU request arbiter.
package alu_pkg;

  localparam int unsigned ALU_W      = 5;
  localparam int unsigned ALU_CTRL_W = 3;
  localparam int unsigned FLG_W      = 4;

  // Position of each ALU flag inside the packed {CO,OVF,N,Z} word
  localparam int unsigned FLG_CO  = 3;
  localparam int unsigned FLG_OVF = 2;
  localparam int unsigned FLG_N   = 1;
  localparam int unsigned FLG_Z   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a lone requester always wins, a tie goes to the
// side selected by i_prio (0 -> requester 0, 1 -> requester 1).
module rr_arb2 (
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_prio,
  output logic o_grant0,
  output logic o_grant1
);

  assign o_grant0 = i_valid0 & (~i_valid1 | ~i_prio);
  assign o_grant1 = i_valid1 & (~i_valid0 |  i_prio);

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one external combinational ALU between two requesters: round-robin
// accept, one-cycle execute, registered response tagged with the requester id.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned W      = ALU_W,
  parameter int unsigned CTRL_W = ALU_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [W-1:0]      req0_a,
  input  logic [W-1:0]      req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [W-1:0]      req1_a,
  input  logic [W-1:0]      req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [W-1:0]      alu_result,
  input  logic [FLG_W-1:0]  alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [W-1:0]      rsp_result,
  output logic [FLG_W-1:0]  rsp_flags
);

  state_t              r_state;
  logic                r_prio;
  logic                r_id;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic [CTRL_W-1:0]   r_ctrl;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [W-1:0]        r_rsp_result;
  logic [FLG_W-1:0]    r_rsp_flags;

  logic                w_grant0;
  logic                w_grant1;
  logic                w_idle;
  logic                w_accept;

  rr_arb2 u_rr_arb2 (
    .i_valid0 (req0_valid),
    .i_valid1 (req1_valid),
    .i_prio   (r_prio),
    .o_grant0 (w_grant0),
    .o_grant1 (w_grant1)
  );

  // Grants are only exposed while idle, so at most one ready is ever high
  assign w_idle     = (r_state == IDLE);
  assign req0_ready = w_idle & w_grant0;
  assign req1_ready = w_idle & w_grant1;
  assign w_accept   = req0_ready | req1_ready;

  // Control FSM with operand and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_prio       <= 1'b0;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_ctrl       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= w_grant1 ? req1_a    : req0_a;
            r_b     <= w_grant1 ? req1_b    : req0_b;
            r_ctrl  <= w_grant1 ? req1_ctrl : req0_ctrl;
            r_id    <= w_grant1;
            r_prio  <= ~w_grant1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_rsp_result <= alu_result;
          r_rsp_flags  <= alu_flags;
          r_rsp_id     <= r_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_ctrl   = r_ctrl;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a behavioural ALU hangs off the ALU port, a
// transaction-level model and a response scoreboard check every cycle.
module tb_alu_req_arbiter;
  import alu_pkg::*;

  localparam int unsigned W  = ALU_W;
  localparam int unsigned CW = ALU_CTRL_W;

  localparam logic [CW-1:0] OP_ADD = 3'd0;
  localparam logic [CW-1:0] OP_SUB = 3'd1;
  localparam logic [CW-1:0] OP_AND = 3'd2;
  localparam logic [CW-1:0] OP_OR  = 3'd3;
  localparam logic [CW-1:0] OP_XOR = 3'd4;
  localparam logic [CW-1:0] OP_NOR = 3'd5;
  localparam logic [CW-1:0] OP_SLL = 3'd6;
  localparam logic [CW-1:0] OP_SRL = 3'd7;

  typedef struct packed {
    logic             id;
    logic [FLG_W-1:0] flg;
    logic [W-1:0]     res;
  } exp_t;

  logic              clk;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [W-1:0]      req0_a, req0_b, req1_a, req1_b;
  logic [CW-1:0]     req0_ctrl, req1_ctrl;
  logic [W-1:0]      alu_a, alu_b, alu_result;
  logic [CW-1:0]     alu_ctrl;
  logic [FLG_W-1:0]  alu_flags;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0]      rsp_result;
  logic [FLG_W-1:0]  rsp_flags;

  int n_checks = 0;
  int n_fail   = 0;

  alu_req_arbiter #(.W(W), .CTRL_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ctrl  (req1_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {flags, result}
  function automatic logic [FLG_W+W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [CW-1:0] c);
    int unsigned      ua, ub, s;
    logic [W-1:0]     r;
    logic [FLG_W-1:0] f;
    logic             co, ov;
    ua = 32'(a);
    ub = 32'(b);
    co = 1'b0;
    ov = 1'b0;
    r  = '0;
    case (c)
      OP_ADD: begin
        s  = ua + ub;
        r  = W'(s);
        co = (s >= 32);
        ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_SUB: begin
        s  = ua + (31 - ub) + 1;
        r  = W'(s);
        co = (s >= 32);
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_SLL: begin r = W'(ua * 2); co = a[W-1]; end
      default: begin r = W'(ua / 2); co = a[0]; end
    endcase
    f          = '0;
    f[FLG_CO]  = co;
    f[FLG_OVF] = ov;
    f[FLG_N]   = r[W-1];
    f[FLG_Z]   = (r == '0);
    return {f, r};
  endfunction

  assign {alu_flags, alu_result} = alu_ref(alu_a, alu_b, alu_ctrl);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one op in flight, response one cycle after accept,
  // ties go to the requester that was not served last
  logic        m_busy;
  int          m_since;
  logic        m_last;
  logic        m_id;
  logic [W-1:0] m_a, m_b;
  logic [CW-1:0] m_c;
  exp_t        m_exp;
  logic        e_r0, e_r1, e_rv;

  assign e_r0 = !m_busy && req0_valid && (!req1_valid || m_last);
  assign e_r1 = !m_busy && req1_valid && (!req0_valid || !m_last);
  assign e_rv = m_busy && (m_since >= 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_since <= 0;
      m_last  <= 1'b1;
      m_id    <= 1'b0;
      m_a     <= '0;
      m_b     <= '0;
      m_c     <= '0;
      m_exp   <= '0;
    end else if (m_busy) begin
      m_since <= m_since + 1;
      if (m_since == 0) m_exp <= {m_id, alu_ref(m_a, m_b, m_c)};
      else if (rsp_ready) m_busy <= 1'b0;
    end else if (e_r0 || e_r1) begin
      m_busy  <= 1'b1;
      m_since <= 0;
      m_id    <= e_r1;
      m_last  <= e_r1;
      m_a     <= e_r1 ? req1_a : req0_a;
      m_b     <= e_r1 ? req1_b : req0_b;
      m_c     <= e_r1 ? req1_ctrl : req0_ctrl;
    end
  end

  exp_t sb_q[$];
  bit   acc0, acc1;

  // Per-cycle compare against the model plus response scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      if (rst_n) begin
        chk("req0_ready", 32'(req0_ready), 32'(e_r0));
        chk("req1_ready", 32'(req1_ready), 32'(e_r1));
        chk("rsp_valid",  32'(rsp_valid),  32'(e_rv));
        chk("alu_a",      32'(alu_a),      32'(m_a));
        chk("alu_b",      32'(alu_b),      32'(m_b));
        chk("alu_ctrl",   32'(alu_ctrl),   32'(m_c));
        if (e_rv) begin
          chk("rsp_id",     32'(rsp_id),     32'(m_exp.id));
          chk("rsp_result", 32'(rsp_result), 32'(m_exp.res));
          chk("rsp_flags",  32'(rsp_flags),  32'(m_exp.flg));
        end
        if (rsp_valid && rsp_ready) begin
          if (sb_q.size() == 0) begin
            chk("sb_unexpected_rsp", 32'(1), 32'(0));
          end else begin
            e = sb_q.pop_front();
            chk("sb_id",     32'(rsp_id),     32'(e.id));
            chk("sb_result", 32'(rsp_result), 32'(e.res));
            chk("sb_flags",  32'(rsp_flags),  32'(e.flg));
          end
        end
        if (acc0) sb_q.push_back({1'b0, alu_ref(req0_a, req0_b, req0_ctrl)});
        if (acc1) sb_q.push_back({1'b1, alu_ref(req1_a, req1_b, req1_ctrl)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_op0();
    req0_a    = W'($urandom);
    req0_b    = W'($urandom);
    req0_ctrl = CW'($urandom);
  endtask

  task automatic new_op1();
    req1_a    = W'($urandom);
    req1_b    = W'($urandom);
    req1_ctrl = CW'($urandom);
  endtask

  initial begin
    logic [W-1:0]  sv_a, sv_b;
    logic [CW-1:0] sv_c;
    logic [FLG_W+W-1:0] sv_rsp;

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_ctrl = '0;
    req1_a = '0; req1_b = '0; req1_ctrl = '0;
    rsp_ready = 1'b1;

    // Reset values
    repeat (2) tick();
    @(negedge clk);
    chk("rst_rsp_valid",  32'(rsp_valid),  32'(0));
    chk("rst_rsp_id",     32'(rsp_id),     32'(0));
    chk("rst_rsp_result", 32'(rsp_result), 32'(0));
    chk("rst_rsp_flags",  32'(rsp_flags),  32'(0));
    chk("rst_alu_a",      32'(alu_a),      32'(0));
    chk("rst_alu_b",      32'(alu_b),      32'(0));
    chk("rst_alu_ctrl",   32'(alu_ctrl),   32'(0));
    chk("rst_ready0",     32'(req0_ready), 32'(0));
    chk("rst_ready1",     32'(req1_ready), 32'(0));

    // req0 add 7+3
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 5'd7; req0_b = 5'd3; req0_ctrl = OP_ADD;
    @(negedge clk);
    chk("t1_ready0", 32'(req0_ready), 32'(1));
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_no_rsp_yet", 32'(rsp_valid), 32'(0));
    tick();
    @(negedge clk);
    chk("t1_rsp_valid",  32'(rsp_valid),  32'(1));
    chk("t1_rsp_id",     32'(rsp_id),     32'(0));
    chk("t1_rsp_result", 32'(rsp_result), 32'(10));
    chk("t1_rsp_flags",  32'(rsp_flags),  32'(4'b0000));
    tick();

    // req1 add 15+1 overflows into the sign bit
    req1_valid = 1'b1; req1_a = 5'd15; req1_b = 5'd1; req1_ctrl = OP_ADD;
    @(negedge clk);
    chk("t3_ready1", 32'(req1_ready), 32'(1));
    chk("t3_ready0", 32'(req0_ready), 32'(0));
    tick();
    req1_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("t3_rsp_id",     32'(rsp_id),     32'(1));
    chk("t3_rsp_result", 32'(rsp_result), 32'(5'b10000));
    chk("t3_rsp_flags",  32'(rsp_flags),  32'(4'b0110));
    tick();

    // Both valid continuously: grants alternate starting with req0
    req0_valid = 1'b1; req1_valid = 1'b1;
    new_op0(); new_op1();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t2_ready0", 32'(req0_ready), 32'((k % 2) == 0));
      chk("t2_ready1", 32'(req1_ready), 32'((k % 2) == 1));
      tick();
      if ((k % 2) == 0) new_op0(); else new_op1();
      tick();
      @(negedge clk);
      chk("t2_rsp_valid", 32'(rsp_valid), 32'(1));
      chk("t2_rsp_id",    32'(rsp_id),    32'(k % 2));
      tick();
    end

    // Back-pressure: response and ALU operands hold while requesters change
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("t4_ready0", 32'(req0_ready), 32'(1));
    sv_a = req0_a; sv_b = req0_b; sv_c = req0_ctrl;
    sv_rsp = alu_ref(sv_a, sv_b, sv_c);
    tick();
    new_op0();
    tick();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_rsp_valid",  32'(rsp_valid),  32'(1));
      chk("t4_ready0",     32'(req0_ready), 32'(0));
      chk("t4_ready1",     32'(req1_ready), 32'(0));
      chk("t4_alu_a",      32'(alu_a),      32'(sv_a));
      chk("t4_alu_b",      32'(alu_b),      32'(sv_b));
      chk("t4_rsp_result", 32'(rsp_result), 32'(sv_rsp[W-1:0]));
      chk("t4_rsp_flags",  32'(rsp_flags),  32'(sv_rsp[FLG_W+W-1:W]));
      tick();
      new_op0(); new_op1();
      if (k == 4) rsp_ready = 1'b1;
    end
    tick();

    // Reset during EXEC drops the op and restores req0 priority
    req1_valid = 1'b0;
    @(negedge clk);
    chk("t5_ready0", 32'(req0_ready), 32'(1));
    tick();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    sb_q.delete();
    req1_valid = 1'b1;
    @(negedge clk);
    chk("t5_rsp_valid", 32'(rsp_valid),  32'(0));
    chk("t5_grant0",    32'(req0_ready), 32'(1));
    chk("t5_grant1",    32'(req1_ready), 32'(0));
    chk("t5_alu_a",     32'(alu_a),      32'(0));
    tick();

    // Random traffic with random back-pressure and operand jitter
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (acc0 || !req0_valid) begin
        req0_valid = ($urandom % 3) != 0;
        new_op0();
      end else if (($urandom % 4) == 0) begin
        new_op0();
      end
      if (acc1 || !req1_valid) begin
        req1_valid = ($urandom % 3) != 0;
        new_op1();
      end else if (($urandom % 4) == 0) begin
        new_op1();
      end
      rsp_ready = ($urandom % 4) != 0;
      tick();
    end

    // Drain and confirm every accepted op was answered
    if (acc0) req0_valid = 1'b0;
    if (acc1) req1_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (acc0) req0_valid = 1'b0;
      if (acc1) req1_valid = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) tick();
    chk("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
